// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO; bits are paced by a one-cycle
// oversample tick. Parity and stop-bit settings are captured per frame.
module uart_tx_fifo #(
  parameter int N          = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          tick_i,
  input  logic [N-1:0]                  data_i,
  input  logic                          data_we_i,
  input  logic                          tx_en_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          two_stop_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          tx_done,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int CW    = $clog2(OVERSAMPLE);
  localparam int BW    = $clog2(N);

  localparam logic [CW-1:0]    TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]    BIT_LAST  = BW'(N - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [N-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_next;
  logic [N-1:0]      head;
  logic [N-1:0]      shreg;
  logic [CW-1:0]     tick_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              stop_cnt;
  logic              par_en_q, par_bit_q, two_stop_q;
  logic              push, pop, bit_end, last_stop, frame_end;
  logic              out_bit;
  logic [N-1:0]      shifted;

  assign head      = mem[rd_ptr];
  assign bit_end   = tick_i && (tick_cnt == TICK_LAST);
  assign last_stop = !two_stop_q || stop_cnt;
  assign frame_end = (state == STOP) && bit_end && last_stop;
  assign push      = data_we_i && !full_o;
  // A frame may start from IDLE on any tick, or chain directly off the last stop bit.
  assign pop       = tx_en_i && !empty_o &&
                     (((state == IDLE) && tick_i) || frame_end);

  assign out_bit = MSB_FIRST ? shreg[N-1] : shreg[0];
  assign shifted = MSB_FIRST ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};

  // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_next = fifo_count_o;
    if (push && !pop)
      count_next = fifo_count_o + 1'b1;
    else if (!push && pop)
      count_next = fifo_count_o - 1'b1;
  end

  // NOTE: the storage array has no reset; pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
      full_o       <= 1'b0;
      empty_o      <= 1'b1;
      overflow_o   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count_o <= count_next;
      full_o       <= (count_next == CNT_FULL);
      empty_o      <= (count_next == '0);
      if (data_we_i && full_o)
        overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      tx_o       <= 1'b1;
      busy_o     <= 1'b0;
      tx_done    <= 1'b0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shreg      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      tx_done <= frame_end;

      if (tick_i && (state != IDLE))
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;

      if (pop) begin
        // Frame settings are captured here and held until the next pop.
        state      <= START;
        tx_o       <= 1'b0;
        busy_o     <= 1'b1;
        shreg      <= head;
        par_en_q   <= parity_en_i;
        par_bit_q  <= (^head) ^ parity_odd_i;
        two_stop_q <= two_stop_i;
      end else begin
        case (state)
          IDLE: ;
          START: begin
            if (bit_end) begin
              tx_o    <= out_bit;
              shreg   <= shifted;
              bit_cnt <= '0;
              state   <= DATA;
            end
          end
          DATA: begin
            if (bit_end) begin
              if (bit_cnt == BIT_LAST) begin
                if (par_en_q) begin
                  tx_o  <= par_bit_q;
                  state <= PARITY;
                end else begin
                  tx_o     <= 1'b1;
                  stop_cnt <= 1'b0;
                  state    <= STOP;
                end
              end else begin
                tx_o    <= out_bit;
                shreg   <= shifted;
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          PARITY: begin
            if (bit_end) begin
              tx_o     <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end
          end
          STOP: begin
            if (bit_end) begin
              if (!last_stop) begin
                stop_cnt <= 1'b1;
              end else begin
                tx_o   <= 1'b1;
                busy_o <= 1'b0;
                state  <= IDLE;
              end
            end
          end
          default: begin
            tx_o   <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: serial framing, parity, stop bits,
// FIFO full/overflow, async reset mid-frame and per-frame config capture.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int N     = 8;
  localparam int OS    = 16;
  localparam int DEPTH = 4;

  logic                        clk_i = 1'b0;
  logic                        rst_i = 1'b1;
  logic                        tick_i = 1'b0;
  logic [N-1:0]                data_i = '0;
  logic                        data_we_i = 1'b0;
  logic                        tx_en_i = 1'b0;
  logic                        parity_en_i = 1'b0;
  logic                        parity_odd_i = 1'b0;
  logic                        two_stop_i = 1'b0;
  logic                        tx_o, busy_o, tx_done, full_o, empty_o, overflow_o;
  logic [$clog2(DEPTH):0]      fifo_count_o;

  int n_run    = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  uart_tx_fifo #(.N(N), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .tick_i       (tick_i),
    .data_i       (data_i),
    .data_we_i    (data_we_i),
    .tx_en_i      (tx_en_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .two_stop_i   (two_stop_i),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .tx_done      (tx_done),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .overflow_o   (overflow_o),
    .fifo_count_o (fifo_count_o)
  );

  initial forever #5 clk_i = ~clk_i;

  // One-clock tick every other clock.
  initial forever begin
    @(negedge clk_i);
    tick_i = ~tick_i;
  end

  always @(negedge clk_i) if (tx_done === 1'b1) done_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_tick();
    do @(posedge clk_i); while (tick_i !== 1'b1);
    #1;
  endtask

  task automatic push(logic [N-1:0] d);
    @(negedge clk_i);
    data_i    = d;
    data_we_i = 1'b1;
    @(negedge clk_i);
    data_we_i = 1'b0;
  endtask

  task automatic wait_start(string tag);
    int waited = 0;
    while (tx_o !== 1'b0 && waited < 2000) begin
      @(posedge clk_i); #1;
      waited++;
    end
    if (tx_o !== 1'b0) check({tag, " start timeout"}, tx_o, 0);
  endtask

  // exp holds the frame bits in transmit order, first bit leftmost.
  task automatic check_frame(string tag, logic [15:0] exp, int nbits);
    logic ok;
    wait_start(tag);
    if (tx_o !== 1'b0) return;
    check({tag, " busy"}, busy_o, 1);
    for (int b = 0; b < nbits; b++) begin
      ok = 1'b1;
      for (int t = 0; t < OS; t++) begin
        if (tx_o !== exp[nbits-1-b]) ok = 1'b0;
        next_tick();
      end
      check($sformatf("%s bit%0d", tag, b), ok, 1);
    end
    check({tag, " done high"}, tx_done, 1);
    @(posedge clk_i); #1;
    check({tag, " done low"}, tx_done, 0);
  endtask

  task automatic check_idle(string tag, int cycles);
    logic ok = 1'b1;
    repeat (cycles) begin
      @(posedge clk_i); #1;
      if (tx_o !== 1'b1 || busy_o !== 1'b0) ok = 1'b0;
    end
    check(tag, ok, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst tx", tx_o, 1);
    check("rst busy", busy_o, 0);
    check("rst done", tx_done, 0);
    check("rst ovf", overflow_o, 0);
    check("rst empty", empty_o, 1);
    check("rst full", full_o, 0);
    check("rst count", fifo_count_o, 0);

    // 1: 0xA5, MSB first, no parity, one stop
    push(8'hA5);
    check("t1 count", fifo_count_o, 1);
    check("t1 empty", empty_o, 0);
    check_idle("t1 hold while disabled", 20);
    tx_en_i = 1'b1;
    check_frame("t1", 16'b0_10100101_1, 10);
    check("t1 done count", done_cnt, 1);
    check("t1 empty after", empty_o, 1);
    check_idle("t1 idle after", 40);

    // 2: even then odd parity on 0x07
    parity_en_i  = 1'b1;
    parity_odd_i = 1'b0;
    push(8'h07);
    check_frame("t2 even", 16'b0_00000111_1_1, 11);
    parity_odd_i = 1'b1;
    push(8'h07);
    check_frame("t2 odd", 16'b0_00000111_0_1, 11);
    check("t2 done count", done_cnt, 3);

    // 3: two stop bits, back-to-back frames
    parity_en_i = 1'b0;
    two_stop_i  = 1'b1;
    tx_en_i     = 1'b0;
    push(8'h00);
    push(8'hFF);
    tx_en_i = 1'b1;
    check_frame("t3a", 16'b0_00000000_11, 11);
    check("t3 no gap", tx_o, 0);
    check_frame("t3b", 16'b0_11111111_11, 11);
    check("t3 done count", done_cnt, 5);

    // 4: fill past full, then drain in order
    two_stop_i = 1'b0;
    tx_en_i    = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    check("t4 ovf before", overflow_o, 0);
    push(8'h55);
    check("t4 full", full_o, 1);
    check("t4 count", fifo_count_o, 4);
    check("t4 ovf", overflow_o, 1);
    check("t4 empty", empty_o, 0);
    tx_en_i = 1'b1;
    check_frame("t4 f0", 16'b0_00010001_1, 10);
    check_frame("t4 f1", 16'b0_00100010_1, 10);
    check_frame("t4 f2", 16'b0_00110011_1, 10);
    check_frame("t4 f3", 16'b0_01000100_1, 10);
    check("t4 empty after", empty_o, 1);
    check_idle("t4 no fifth frame", 300);
    check("t4 done count", done_cnt, 9);
    check("t4 ovf sticky", overflow_o, 1);

    // 6: config changes mid-frame apply only to the next frame
    parity_en_i  = 1'b1;
    parity_odd_i = 1'b0;
    two_stop_i   = 1'b0;
    tx_en_i      = 1'b0;
    push(8'h3C);
    push(8'h3C);
    tx_en_i = 1'b1;
    fork
      check_frame("t6a", 16'b0_00111100_0_1, 11);
      begin
        repeat (100) @(negedge clk_i);
        parity_odd_i = 1'b1;
        two_stop_i   = 1'b1;
      end
    join
    check_frame("t6b", 16'b0_00111100_1_11, 12);
    check("t6 done count", done_cnt, 11);

    // 5: async reset during data bit 3
    parity_en_i  = 1'b0;
    parity_odd_i = 1'b0;
    two_stop_i   = 1'b0;
    tx_en_i      = 1'b0;
    push(8'h81);
    push(8'h99);
    tx_en_i = 1'b1;
    wait_start("t5");
    repeat (72) next_tick();
    check("t5 busy mid", busy_o, 1);
    check("t5 data bit3", tx_o, 0);
    #1 rst_i = 1'b1;
    #1;
    check("t5 rst tx", tx_o, 1);
    check("t5 rst busy", busy_o, 0);
    check("t5 rst empty", empty_o, 1);
    check("t5 rst full", full_o, 0);
    check("t5 rst count", fifo_count_o, 0);
    check("t5 rst ovf", overflow_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    check_idle("t5 idle after reset", 200);
    check("t5 done count", done_cnt, 11);
    push(8'hC3);
    check_frame("t5 new", 16'b0_11000011_1, 10);
    check("t5 final done count", done_cnt, 12);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor UART transmitter. All logic runs on a single system clock; a one-cycle `tick_i` enable paces the serial line at OVERSAMPLE ticks per bit. Features:
- Built-in write FIFO.
- Configurable data width and bit order.
- Run-time parity (none/even/odd) and 1 or 2 stop bits.
- Sits between the CPU/CRC datapath and the serial pin, fed by the same baud-tick generator as the receiver.

Parameters:
N, 8, data bits per frame (5..9)
OVERSAMPLE, 16, tick_i pulses per serial bit (4..32)
FIFO_DEPTH, 4, FIFO entries (power of two, >=2)
MSB_FIRST, 1, 1 = data MSB sent first; 0 = LSB first

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  asynchronous active-high reset
tick_i  in  1  oversample enable, one clk_i wide
data_i  in  N  write data
data_we_i  in  1  push data_i into FIFO
tx_en_i  in  1  permit starting new frames
parity_en_i  in  1  insert parity bit
parity_odd_i  in  1  1 = odd parity, 0 = even
two_stop_i  in  1  1 = two stop bits
tx_o  out  1  serial line, idle high
busy_o  out  1  frame in progress (state != IDLE)
tx_done  out  1  one-clk pulse when last stop bit completes
full_o  out  1  FIFO full
empty_o  out  1  FIFO empty
overflow_o  out  1  sticky: write attempted while full
fifo_count_o  out  $clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset (async assert, sync-release safe):
  - tx_o=1, busy_o=0, tx_done=0, overflow_o=0.
  - FIFO emptied: empty_o=1, full_o=0, fifo_count_o=0.
  - State IDLE, counters cleared.
  - Reset mid-frame aborts the frame; line returns high immediately.
- FIFO write:
  - data_we_i && !full_o pushes data_i; count increments the next clk.
  - data_we_i && full_o drops the data and sets overflow_o; it stays set until rst_i.
  - Push and pop in the same clk: both occur and the count is unchanged. When full, the pop happens and the push is still rejected, because full_o is evaluated pre-edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: on a clk with tick_i && tx_en_i && !empty_o.
  - Pops the head into the shift register.
  - Latches parity_en_i, parity_odd_i and two_stop_i for the whole frame; config changes mid-frame have no effect.
  - Computes parity over the N data bits: even => XOR of the bits; odd => its inverse.
  - tx_o=0 from the following clk.
- Bit timing:
  - Tick counter runs 0..OVERSAMPLE-1 and advances only on tick_i.
  - A bit ends on the tick where counter==OVERSAMPLE-1; the counter wraps to 0 and the next bit's tx_o value is registered on that same clk.
  - Every bit, including the start bit, lasts exactly OVERSAMPLE ticks.
- START -> DATA after 1 bit.
- DATA shifts N bits, MSB or LSB first per MSB_FIRST. Then -> PARITY if parity is enabled, else -> STOP.
- PARITY transmits 1 bit, then -> STOP.
- STOP holds tx_o=1 for 1 or 2 bits. On completion of the last stop bit:
  - tx_done pulses for one clk.
  - The next state is decided on that same clk: IDLE, or directly START if tx_en_i && !empty_o. Back-to-back frames have no idle gap beyond the stop bits.
- Frame length is (1+N+P+S)*OVERSAMPLE ticks.
- tx_en_i deasserted mid-frame: the current frame completes and no new frame starts.
- tick_i with the FSM in IDLE and the FIFO empty: no effect.
- busy_o is a registered state decode.
- fifo_count_o, full_o and empty_o are registered and update the clk after push/pop.

Test Plan:
1. N=8, MSB_FIRST=1, no parity, one stop. Push 0xA5, tx_en_i=1 -> tx_o = 0,1,0,1,0,0,1,0,1,1, each held 16 ticks; tx_done pulses once; empty_o=1 afterwards.
2. parity_en_i=1, parity_odd_i=0, push 0x07 -> parity bit 1. Repeat with parity_odd_i=1 -> parity bit 0. Frame length is 11 bits.
3. two_stop_i=1, push 0x00 and 0xFF back-to-back -> stop high for exactly 32 ticks, next start bit follows immediately, one tx_done per frame.
4. tx_en_i=0, push 5 words into FIFO_DEPTH=4 -> full_o=1, fifo_count_o=4, overflow_o=1, 5th word lost. Enable -> exactly 4 frames, in order.
5. Assert rst_i during DATA bit 3 -> tx_o=1, busy_o=0 and FIFO empty with no clock edge required; after release no frame starts until a new push.
6. Toggle parity_odd_i and two_stop_i mid-frame -> frame unaffected; the next frame uses the new settings.
